// File: rtl/register_file_32x32_pkg.sv
// Shared datapath widths and named MIPS register numbers for the register file,
// ALU and write-back muxes.
package register_file_32x32_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] reg_num_t;

  localparam reg_num_t REG_ZERO = 5'd0;
  localparam reg_num_t REG_AT   = 5'd1;
  localparam reg_num_t REG_V0   = 5'd2;
  localparam reg_num_t REG_A0   = 5'd4;
  localparam reg_num_t REG_T0   = 5'd8;
  localparam reg_num_t REG_S0   = 5'd16;
  localparam reg_num_t REG_GP   = 5'd28;
  localparam reg_num_t REG_SP   = 5'd29;
  localparam reg_num_t REG_FP   = 5'd30;
  localparam reg_num_t REG_RA   = 5'd31;

endpackage

// File: rtl/register_file_32x32_decoder5to32.sv
// Binary-to-one-hot decoder; output is all-zero while en is low.
module decoder5to32 #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] onehot
);

  // NOTE: default assignment first so every path drives onehot and no latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/register_file_32x32_mux32.sv
// Word selector: picks one of 2**ADDR_W packed words by index.
module mux32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] words,
  input  logic [ADDR_W-1:0]                sel,
  output logic [DATA_W-1:0]                y
);

  assign y = words[sel];

endmodule

// File: rtl/register_file_32x32.sv
// MIPS register file: one synchronous write port, two combinational read ports,
// register 0 hardwired to zero, optional write-through bypass.
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]              dec_vec;
  logic [NREG-1:0]              we;
  logic                         unused_zero_hit;
  logic [DATA_W-1:0]            regs [NREG-1:1];
  logic [NREG-1:0][DATA_W-1:0]  words;
  logic [DATA_W-1:0]            stored1, stored2;

  decoder5to32 #(.ADDR_W(ADDR_W)) u_wdec (
    .addr   (writeReg),
    .en     (regWrite),
    .onehot (dec_vec)
  );

  // Address 0 has no storage, so its enable is forced low and left to dangle.
  assign we              = {dec_vec[NREG-1:1], 1'b0};
  assign unused_zero_hit = dec_vec[0];

  // NOTE: this storage is a flop array that must read 0 after reset, so it is
  // reset explicitly; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (reset)      regs[i] <= '0;
      else if (we[i]) regs[i] <= writeData;
    end
  end

  always_comb begin
    words[0] = '0;
    for (int i = 1; i < NREG; i++) words[i] = regs[i];
  end

  mux32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rsel1 (
    .words (words),
    .sel   (readReg1),
    .y     (stored1)
  );

  mux32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rsel2 (
    .words (words),
    .sel   (readReg2),
    .y     (stored2)
  );

  generate
    if (WRITE_BYPASS) begin : g_bypass
      // Write-through is held off during reset so reads show stored values until the clearing edge.
      logic byp_active;
      assign byp_active = regWrite && !reset && (writeReg != REG_ZERO);
      assign readData1  = (byp_active && readReg1 == writeReg) ? writeData : stored1;
      assign readData2  = (byp_active && readReg2 == writeReg) ? writeData : stored2;
    end else begin : g_no_bypass
      assign readData1 = stored1;
      assign readData2 = stored2;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array model, run on a plain instance and a write-through instance in parallel.
module tb_register_file_32x32;
  import register_file_32x32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1, readReg2;
  logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  register_file_32x32 #(.WRITE_BYPASS(1'b0)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_nb), .readData2(rd2_nb)
  );

  register_file_32x32 #(.WRITE_BYPASS(1'b1)) dut_bp (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_bp), .readData2(rd2_bp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural rules, for either bypass setting.
  function automatic logic [31:0] expect_read(input logic [4:0] addr, input bit bypass);
    if (addr == 5'd0) return 32'h0;
    if (bypass && regWrite && !reset && addr == writeReg) return writeData;
    return model[addr];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "/nb/rd1"}, rd1_nb, expect_read(readReg1, 1'b0));
    check({tag, "/nb/rd2"}, rd2_nb, expect_read(readReg2, 1'b0));
    check({tag, "/bp/rd1"}, rd1_bp, expect_read(readReg1, 1'b1));
    check({tag, "/bp/rd2"}, rd2_bp, expect_read(readReg2, 1'b1));
  endtask

  // Called in the negedge phase; advances one rising edge and updates the model.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (regWrite && writeReg != 5'd0) begin
      model[writeReg] = writeData;
    end
    @(negedge clk);
  endtask

  task automatic sweep(input string tag);
    regWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      check_reads(tag);
      @(negedge clk);
    end
  endtask

  task automatic write(input logic [4:0] r, input logic [31:0] d);
    regWrite  = 1'b1;
    writeReg  = r;
    writeData = d;
    cycle();
    regWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    @(negedge clk);
    cycle();
    reset = 1'b0;
    sweep("reset_sweep");

    write(REG_T0, 32'hDEAD_BEEF);
    readReg1 = REG_T0; #1;
    check("basic_rd1", rd1_nb, 32'hDEAD_BEEF);
    @(negedge clk);
    sweep("basic_sweep");

    write(REG_ZERO, 32'hFFFF_FFFF);
    readReg2 = REG_ZERO; #1;
    check("zero_rd2", rd2_nb, 32'h0);
    check("zero_rd2_bp", rd2_bp, 32'h0);
    @(negedge clk);
    sweep("zero_sweep");

    regWrite = 1'b0; writeReg = 5'd9; writeData = 32'h1234_5678;
    cycle();
    readReg1 = 5'd9; #1;
    check("wdis_reg9", rd1_nb, 32'h0);
    @(negedge clk);

    write(REG_RA, 32'h0000_0004);
    regWrite = 1'b1; writeReg = REG_RA; writeData = 32'h0000_0100; readReg1 = REG_RA;
    #1;
    check("hazard_pre_nb", rd1_nb, 32'h0000_0004);
    check("hazard_pre_bp", rd1_bp, 32'h0000_0100);
    cycle();
    regWrite = 1'b0; #1;
    check("hazard_post_nb", rd1_nb, 32'h0000_0100);
    check("hazard_post_bp", rd1_bp, 32'h0000_0100);
    @(negedge clk);

    write(5'd3, 32'hA5A5_A5A5);
    reset = 1'b1; regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h5A5A_5A5A; readReg1 = 5'd3;
    #1;
    check("rstpri_pre_bp", rd1_bp, 32'hA5A5_A5A5);
    cycle();
    reset = 1'b0; regWrite = 1'b0; #1;
    check("rstpri_post", rd1_nb, 32'h0);
    check("rstpri_post_bp", rd1_bp, 32'h0);
    @(negedge clk);
    write(5'd3, 32'h5A5A_5A5A);
    #1;
    check("rstpri_rewrite", rd1_nb, 32'h5A5A_5A5A);
    @(negedge clk);

    // Random traffic; writeData sometimes changes mid-cycle, only the edge value counts.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      regWrite  = $urandom_range(0, 3) != 0;
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
      readReg2  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      #1;
      check_reads("rand");
      if ($urandom_range(0, 3) == 0) begin
        #1;
        writeData = $urandom;
      end
      cycle();
    end
    reset = 1'b0;
    sweep("final_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
